// File: rtl/bexkat1_pkg.sv
// Shared types for the bexkat1 hazard/forwarding scoreboard.
// Entries carry a fixed-width dst so one struct serves every NREGS up to 256.
package bexkat1_pkg;

    localparam int unsigned MaxRaw = 8;
    localparam int unsigned MaxSw  = 4;

    typedef struct packed {
        logic              vld;
        logic              we;
        logic              ld;
        logic [MaxRaw-1:0] dst;
    } scb_entry_t;

    typedef logic [MaxSw-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = '0;

endpackage

// File: rtl/bexkat1_scoreboard_if.sv
// Issue-side bundle between idecode and the scoreboard.
// Master is the decode stage, slave is the scoreboard.
interface bexkat1_scoreboard_if #(
    parameter int unsigned NSTAGES = 3,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned NSRC    = 2
);
    localparam int unsigned RAW = $clog2(NREGS);
    localparam int unsigned SW  = $clog2(NSTAGES + 1);

    logic                issue_vld;
    logic                issue_we;
    logic                issue_ld;
    logic [RAW-1:0]      issue_dst;
    logic [NSRC*RAW-1:0] issue_src;
    logic [NSRC-1:0]     issue_use;
    logic                advance;
    logic [NSTAGES-1:0]  flush;
    logic [NSRC*SW-1:0]  fwd_sel;
    logic                stall;
    logic [NREGS-1:0]    busy;

    modport master (
        output issue_vld, issue_we, issue_ld, issue_dst, issue_src, issue_use, advance, flush,
        input  fwd_sel, stall, busy
    );

    modport slave (
        input  issue_vld, issue_we, issue_ld, issue_dst, issue_src, issue_use, advance, flush,
        output fwd_sel, stall, busy
    );

endinterface

// File: rtl/bexkat1_scb_match.sv
// Priority match of one source operand against the in-flight stage array.
// Returns the youngest matching stage and whether its result is not yet produced.
module bexkat1_scb_match
    import bexkat1_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned LOAD_STAGE = 2
) (
    input  scb_entry_t [NSTAGES-1:0] ents,
    input  logic [MaxRaw-1:0]        src,
    input  logic                     use_op,
    output fwd_sel_t                 sel,
    output logic                     not_ready
);

    always_comb begin
        sel       = FWD_RF;
        not_ready = 1'b0;
        // Oldest first, so a younger match simply overwrites an older one.
        for (int k = int'(NSTAGES); k >= 1; k--) begin
            if (use_op && ents[k-1].vld && ents[k-1].we && (ents[k-1].dst == src)) begin
                sel       = fwd_sel_t'(k);
                not_ready = ents[k-1].ld && (k < int'(LOAD_STAGE));
            end
        end
    end

endmodule

// File: rtl/bexkat1_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight destinations over NSTAGES stages,
// selects a forwarding source per operand and stalls issue on load-use.
module bexkat1_scoreboard
    import bexkat1_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned NREGS      = 16,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned LOAD_STAGE = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    bexkat1_scoreboard_if.slave bus
);

    localparam int unsigned RAW = $clog2(NREGS);
    localparam int unsigned SW  = $clog2(NSTAGES + 1);

    if (LOAD_STAGE > NSTAGES || LOAD_STAGE < 1 || NSTAGES > 7 || NREGS > 256)
    begin : g_bad_params
        $error("bexkat1_scoreboard: illegal LOAD_STAGE/NSTAGES/NREGS combination");
    end

    scb_entry_t [NSTAGES-1:0] ent_q, ent_d;
    logic [NSRC-1:0]          not_ready;
    logic                     stall;

    for (genvar j = 0; j < NSRC; j++) begin : g_match
        fwd_sel_t sel;
        logic     unused_sel;

        bexkat1_scb_match #(
            .NSTAGES    (NSTAGES),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_match (
            .ents      (ent_q),
            .src       (MaxRaw'(bus.issue_src[j*RAW +: RAW])),
            .use_op    (bus.issue_use[j]),
            .sel       (sel),
            .not_ready (not_ready[j])
        );

        assign bus.fwd_sel[j*SW +: SW] = sel[SW-1:0];
        assign unused_sel              = ^sel[MaxSw-1:SW];
    end

    assign stall     = bus.issue_vld & (|not_ready);
    assign bus.stall = stall;

    always_comb begin
        bus.busy = '0;
        for (int k = 0; k < int'(NSTAGES); k++) begin
            if (ent_q[k].vld && ent_q[k].we) begin
                bus.busy[ent_q[k].dst[RAW-1:0]] = 1'b1;
            end
        end
    end

    // Flush kills the entry where it sits; the shift then carries the dead copy.
    always_comb begin
        ent_d = ent_q;
        for (int k = 0; k < int'(NSTAGES); k++) begin
            if (bus.flush[k]) begin
                ent_d[k].vld = 1'b0;
            end
        end
        if (bus.advance) begin
            for (int k = int'(NSTAGES) - 1; k >= 1; k--) begin
                ent_d[k] = ent_d[k-1];
            end
            ent_d[0] = '{vld: bus.issue_vld & ~stall,
                         we:  bus.issue_we,
                         ld:  bus.issue_ld,
                         dst: MaxRaw'(bus.issue_dst)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule
